ysyx_23060077_riscv_lsu_axi: RTL
================================

# ysyx_23060077_riscv_lsu_axi

Parametrised load/store unit: accepts one load or store per request handshake from the EXU, performs the access as a single-beat AXI4-Lite master transaction with byte-lane strobes derived from the address offset, and returns sign/zero-extended load data or store completion. Successor of the fixed 32-bit LSU: it adds width parametrisation, RV64 sizes, misalignment/illegal-size trapping, bus-error reporting and an explicit request/response handshake. It sits between the EXU and the memory-side AXI arbiter.

## Interface
- DATA_WIDTH, 32: register and bus data width, 32 or 64.
- ADDR_WIDTH, 32: AXI address width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid / in_ready  in / out  1 / 1  request handshake.
- in_store  in  1  1 = store, 0 = load.
- in_funct3  in  3  RISC-V funct3 (size/sign).
- in_addr  in  ADDR_WIDTH  effective address (src1+imm, computed upstream).
- in_wdata  in  DATA_WIDTH  store data, LSB-justified.
- out_valid  out  1  one-cycle completion pulse.
- out_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- out_err  out  2  0 none, 1 misaligned, 2 bus error (RESP≠OKAY), 3 illegal funct3.
- mem_stall  out  1  high whenever state ≠ IDLE and out_valid low.
- AXI4-Lite master: araddr, arvalid, arready, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, wstrb (DATA_WIDTH/8), wvalid, wready, bresp, bvalid, bready.

## Operation
- Sizes: 000 b, 001 h, 010 w, 011 d (DATA_WIDTH=64 only), 100 bu, 101 hu, 110 wu (64 only, load only). Stores accept 000–011 only; anything else → err 3.
- Misaligned: addr not a multiple of access size → err 1. Errors detected at accept issue no bus transaction.
- OFF = log2(DATA_WIDTH/8). araddr/awaddr = in_addr with low OFF bits cleared.
- Store: wdata = in_wdata size-slice replicated across lanes; wstrb = ((1<<bytes)-1) << addr[OFF-1:0].
- Load: rdata >> (8·addr[OFF-1:0]), then size-truncate and sign/zero-extend to DATA_WIDTH.
- Request fields are latched at accept; inputs ignored afterwards.
- FSM: IDLE → (load) AR → R → RESP; (store) AW_W → B → RESP; (error) RESP; RESP → IDLE.
- AR: arvalid held until arready. R: rready=1 until rvalid; latch rdata/rresp.
- AW_W: awvalid and wvalid raised together, each dropped independently on its own handshake; leave when both done (either order or same cycle). B: bready=1 until bvalid; latch bresp.
- RESP: out_valid=1 for exactly one cycle with latched data/err; no backpressure from EXU.
- in_ready = (state == IDLE). One outstanding transaction, never more.

## Timing
- Reset (async, any state incl. mid-transaction): state IDLE; in_ready=1; out_valid, arvalid, awvalid, wvalid, rready, bready, mem_stall = 0; out_rdata=0, out_err=0, address/data/strobe registers 0. A slave mid-handshake is abandoned.
- Accept at cycle 0 (in_valid & in_ready). Zero-wait slave: load arvalid cycle 1, rready/rvalid cycle 2, out_valid cycle 3; store aw/w cycle 1, b cycle 2, out_valid cycle 3.
- Error at accept: out_valid cycle 1, no AXI valid ever raised.
- Each slave wait cycle adds exactly one cycle. AXI valids never deasserted before handshake.
- Next request accepted at the cycle after out_valid at earliest (RESP→IDLE).

## Structure
- Shared define/package: funct3 size encodings, err codes, FSM state encoding, AXI RESP OKAY constant.
- Sub-module ysyx_23060077_riscv_lsu_lane (combinational, parametrised DATA_WIDTH): strobe/wdata alignment and rdata extraction/extension. FSM and AXI registers stay in top.

## Test plan
- DATA_WIDTH=32, lb at 0x8000_0003, slave rdata=0x80FF_0000, zero-wait → out_valid cycle 3, out_rdata=0xFFFF_FF80, out_err=0.
- sh wdata=0x1234_ABCD at 0x8000_0002 → awaddr=0x8000_0000, wdata=0xABCD_ABCD, wstrb=0b1100; aw accepted 2 cycles before w → completes correctly.
- lw at 0x8000_0006 → out_valid cycle 1, out_err=1, arvalid never high.
- DATA_WIDTH=64, lwu at 0x8000_0004, rdata=0xF000_0001_0000_0000 → out_rdata=0x0000_0000_F000_0001; ld at 0x…8 with rresp=SLVERR → out_err=2.
- ld with DATA_WIDTH=32, and sb with funct3=100 → out_err=3, no transaction.
- rst_n low while in R with arready done, rvalid pending → all AXI valids/readies 0 immediately, in_ready=1; next load completes normally.

Source files
------------

// File: rtl/ysyx_23060077_riscv_lsu_axi_pkg.sv
// Shared encodings for the LSU: access sizes, error codes, FSM states, AXI response.
package ysyx_23060077_riscv_lsu_axi_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } lsu_err_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_e;

  // Doubleword and unsigned-word exist only on a 64-bit datapath; unsigned sizes are load-only.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3, input logic is64);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_D:             return is64;
      F3_BU, F3_HU:     return !store;
      F3_WU:            return !store && is64;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060077_riscv_lsu_axi_lane.sv
// Byte-lane steering: store data replication and strobes, load data extraction and extension.
module ysyx_23060077_riscv_lsu_lane
  import ysyx_23060077_riscv_lsu_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                        funct3_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  output logic [DATA_WIDTH-1:0]             wdata_o,
  output logic [DATA_WIDTH/8-1:0]           wstrb_o,
  output logic [DATA_WIDTH-1:0]             rdata_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [STRB_W-1:0]     strb_mask;
  logic [DATA_WIDTH-1:0] shifted;

  // Store side: replicate the size slice on every lane, strobe only the addressed bytes.
  always_comb begin
    strb_mask = '1;
    wdata_o   = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        strb_mask = STRB_W'(1);
        wdata_o   = {STRB_W{wdata_i[7:0]}};
      end
      2'b01: begin
        strb_mask = STRB_W'(3);
        wdata_o   = {(DATA_WIDTH/16){wdata_i[15:0]}};
      end
      2'b10: begin
        strb_mask = STRB_W'(15);
        wdata_o   = {(DATA_WIDTH/32){wdata_i[31:0]}};
      end
      default: begin
        strb_mask = '1;
        wdata_o   = wdata_i;
      end
    endcase
    wstrb_o = strb_mask << offset_i;
  end

  // Load side: bring the addressed bytes down to bit 0, then truncate and extend.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = DATA_WIDTH'($signed(shifted[7:0]));
      F3_BU:   rdata_o = DATA_WIDTH'(shifted[7:0]);
      F3_H:    rdata_o = DATA_WIDTH'($signed(shifted[15:0]));
      F3_HU:   rdata_o = DATA_WIDTH'(shifted[15:0]);
      F3_W:    rdata_o = DATA_WIDTH'($signed(shifted[31:0]));
      F3_WU:   rdata_o = DATA_WIDTH'(shifted[31:0]);
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060077_riscv_lsu_axi.sv
// Load/store unit: one EXU request at a time, performed as a single-beat AXI4-Lite access.
//
// state   | meaning
// IDLE    | ready for a request
// AR      | read address presented, waiting for arready
// R       | waiting for read data
// AW_W    | write address and data presented, each retired on its own handshake
// B       | waiting for write response
// RESP    | one-cycle completion pulse towards the EXU
module ysyx_23060077_riscv_lsu_axi
  import ysyx_23060077_riscv_lsu_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_store_i,
  input  logic [2:0]              in_funct3_i,
  input  logic [ADDR_WIDTH-1:0]   in_addr_i,
  input  logic [DATA_WIDTH-1:0]   in_wdata_i,
  output logic                    out_valid_o,
  output logic [DATA_WIDTH-1:0]   out_rdata_o,
  output logic [1:0]              out_err_o,
  output logic                    mem_stall_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);

  lsu_state_e            state_q, state_d;
  logic [2:0]            funct3_q;
  logic [OFF-1:0]        off_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            err_q;
  logic                  aw_done_q, w_done_q;

  logic                  accept;
  logic [2:0]            size_mask;
  lsu_err_e              acc_err;
  logic [2:0]            lane_f3;
  logic [OFF-1:0]        lane_off;
  logic [DATA_WIDTH-1:0] lane_wdata, lane_rdata;
  logic [STRB_W-1:0]     lane_wstrb;

  assign accept = in_valid_i && (state_q == ST_IDLE);

  // Classify the incoming request; an illegal size outranks misalignment.
  always_comb begin
    size_mask = 3'((4'd1 << in_funct3_i[1:0]) - 4'd1);
    if (!f3_legal(in_store_i, in_funct3_i, DATA_WIDTH == 64))
      acc_err = ERR_ILLEGAL;
    else if ((in_addr_i[2:0] & size_mask) != 3'b000)
      acc_err = ERR_MISALIGN;
    else
      acc_err = ERR_NONE;
  end

  // The lane sees the live request while idle (store alignment) and the latched one afterwards (load extraction).
  always_comb begin
    lane_f3  = (state_q == ST_IDLE) ? in_funct3_i : funct3_q;
    lane_off = (state_q == ST_IDLE) ? in_addr_i[OFF-1:0] : off_q;
  end

  ysyx_23060077_riscv_lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .funct3_i (lane_f3),
    .offset_i (lane_off),
    .wdata_i  (in_wdata_i),
    .rdata_i  (rdata_i),
    .wdata_o  (lane_wdata),
    .wstrb_o  (lane_wstrb),
    .rdata_o  (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (acc_err != ERR_NONE) state_d = ST_RESP;
        else if (in_store_i)     state_d = ST_AW_W;
        else                     state_d = ST_AR;
      end
      ST_AR:   if (arready_i) state_d = ST_R;
      ST_R:    if (rvalid_i)  state_d = ST_RESP;
      ST_AW_W: if ((aw_done_q || awready_i) && (w_done_q || wready_i)) state_d = ST_B;
      ST_B:    if (bvalid_i)  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_RESP);
    mem_stall_o = (state_q != ST_IDLE) && (state_q != ST_RESP);
    arvalid_o   = (state_q == ST_AR);
    rready_o    = (state_q == ST_R);
    awvalid_o   = (state_q == ST_AW_W) && !aw_done_q;
    wvalid_o    = (state_q == ST_AW_W) && !w_done_q;
    bready_o    = (state_q == ST_B);
  end

  // Request latch, write-channel progress and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q  <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_NONE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q  <= in_funct3_i;
        off_q     <= in_addr_i[OFF-1:0];
        addr_q    <= {in_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        err_q     <= acc_err;
        rdata_q   <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (in_store_i && (acc_err == ERR_NONE)) begin
          wdata_q <= lane_wdata;
          wstrb_q <= lane_wstrb;
        end else begin
          wdata_q <= '0;
          wstrb_q <= '0;
        end
      end
      if (state_q == ST_AW_W) begin
        if (awvalid_o && awready_i) aw_done_q <= 1'b1;
        if (wvalid_o && wready_i)   w_done_q  <= 1'b1;
      end
      if ((state_q == ST_R) && rvalid_i) begin
        if (rresp_i == AXI_RESP_OKAY) rdata_q <= lane_rdata;
        else                          err_q   <= ERR_BUS;
      end
      if ((state_q == ST_B) && bvalid_i && (bresp_i != AXI_RESP_OKAY))
        err_q <= ERR_BUS;
    end
  end

  assign araddr_o    = addr_q;
  assign awaddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign out_rdata_o = rdata_q;
  assign out_err_o   = err_q;

endmodule
